// File: rtl/seq_rotate_right.sv
// Multi-cycle right-rotator: captures an operand and rotates it right one position per cycle
// under a start/done handshake, reporting dropped requests made while busy.
module seq_rotate_right #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_rot;

  assign data_rot = {data_q[0], data_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    out_d       = out_q;
    // Any request outside IDLE is dropped and flagged for one cycle.
    err_d       = start && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d      = In;
          remaining_d = Cnt;
          if (Cnt == '0) begin
            state_d = StDone;
            out_d   = In;
          end else begin
            state_d = StRot;
          end
        end
      end
      StRot: begin
        data_d      = data_rot;
        remaining_d = remaining_q - CNT_W'(1);
        // Last rotation: publish the rotated value as we enter DONE.
        if (remaining_q == CNT_W'(1)) begin
          state_d = StDone;
          out_d   = data_rot;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      remaining_q <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = err_q;

endmodule
